// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: access type codes, FSM states
// and the misalignment rule used by the responder and its load extractor.
package dsram_responder_pkg;

  localparam logic [3:0] LD_W  = 4'b0000;
  localparam logic [3:0] LD_B  = 4'b0001;
  localparam logic [3:0] LD_BU = 4'b0010;
  localparam logic [3:0] LD_H  = 4'b0011;
  localparam logic [3:0] LD_HU = 4'b0100;
  localparam logic [3:0] ST_B  = 4'b0101;
  localparam logic [3:0] ST_H  = 4'b0111;

  localparam int DSRAM_WAIT_MAX = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Byte accesses never fault; halves need addr[0]=0; everything else is a word.
  function automatic logic is_misaligned(input logic [3:0] i_type, input logic [1:0] i_off);
    logic w_mis;
    case (i_type)
      LD_B, LD_BU, ST_B: w_mis = 1'b0;
      LD_H, LD_HU, ST_H: w_mis = i_off[0];
      default:           w_mis = (i_off != 2'b00);
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// EX-stage data-memory bus: request from EX, response and stall back to the pipeline.
interface dsram_responder_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [3:0]  data_ram_read;
  logic [31:0] rdata;
  logic [31:0] load_result;
  logic        rvalid;
  logic        misalign_err;
  logic        stallreq_for_mem;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, data_ram_read,
    input  rdata, load_result, rvalid, misalign_err, stallreq_for_mem
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, data_ram_read,
    output rdata, load_result, rvalid, misalign_err, stallreq_for_mem
  );

endinterface

// File: rtl/dsram_responder_load_ext.sv
// Load extractor: picks the byte/half/word addressed by the low address bits and
// sign- or zero-extends it according to the access type. Shared with MEM.
module dsram_responder_load_ext
  import dsram_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_type,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension per type
  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_type)
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_result = {24'h000000, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_HU:   o_result = {16'h0000, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: word-organised array with byte-lane writes, registered
// read response and an optional wait-state counter that stalls the pipeline.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  dsram_responder_if.slave  bus
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] WAIT_L = 4'((WAIT_CYCLES > DSRAM_WAIT_MAX) ? DSRAM_WAIT_MAX : WAIT_CYCLES);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [ADDR_W+1:0]  r_addr;
  logic [3:0]         r_wen, r_type;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mem [0:DEPTH-1];
  logic [31:0]        r_rdata, r_load;
  logic               r_rvalid, r_err;

  logic               w_accept, w_complete, w_stall;
  logic [ADDR_W+1:0]  w_addr;
  logic [3:0]         w_wen, w_type;
  logic [31:0]        w_wdata, w_word, w_load;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_misalign, w_wr_en;
  logic               w_unused_addr;

  // While BUSY the held request on the bus is ignored in favour of the latched copy
  assign w_addr     = (r_state == S_BUSY) ? r_addr  : bus.data_sram_addr[ADDR_W+1:0];
  assign w_wen      = (r_state == S_BUSY) ? r_wen   : bus.data_sram_wen;
  assign w_wdata    = (r_state == S_BUSY) ? r_wdata : bus.data_sram_wdata;
  assign w_type     = (r_state == S_BUSY) ? r_type  : bus.data_ram_read;
  assign w_idx      = w_addr[ADDR_W+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_misalign = is_misaligned(w_type, w_addr[1:0]);
  assign w_wr_en    = w_complete & ~w_misalign & (w_wen != 4'b0000) & ~rst;

  assign w_unused_addr = &{1'b0, bus.data_sram_addr[31:ADDR_W+2]};

  dsram_responder_load_ext u_load_ext (
    .i_word   (w_word),
    .i_off    (w_addr[1:0]),
    .i_type   (w_type),
    .o_result (w_load)
  );

  // Next-state, wait counter and stall request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.data_sram_en) begin
          if (WAIT_L == 4'd0) begin
            w_complete = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_cnt_nxt   = WAIT_L;
            w_state_nxt = S_BUSY;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latch taken in the accept cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wen   <= 4'b0000;
      r_wdata <= 32'h0000_0000;
      r_type  <= 4'b0000;
    end else if (w_accept) begin
      r_addr  <= bus.data_sram_addr[ADDR_W+1:0];
      r_wen   <= bus.data_sram_wen;
      r_wdata <= bus.data_sram_wdata;
      r_type  <= bus.data_ram_read;
    end
  end

  // Byte-lane write into the array; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en && w_wen[0]) r_mem[w_idx][7:0]   <= w_wdata[7:0];
    if (w_wr_en && w_wen[1]) r_mem[w_idx][15:8]  <= w_wdata[15:8];
    if (w_wr_en && w_wen[2]) r_mem[w_idx][23:16] <= w_wdata[23:16];
    if (w_wr_en && w_wen[3]) r_mem[w_idx][31:24] <= w_wdata[31:24];
  end

  // Response registers; rdata is the pre-write word, data holds while rvalid=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0000_0000;
      r_load   <= 32'h0000_0000;
    end else begin
      r_rvalid <= w_complete;
      r_err    <= w_complete & w_misalign;
      if (w_complete) begin
        if (w_misalign) begin
          r_rdata <= 32'h0000_0000;
          r_load  <= 32'h0000_0000;
        end else begin
          r_rdata <= w_word;
          r_load  <= (w_wen == 4'b0000) ? w_load : 32'h0000_0000;
        end
      end
    end
  end

  assign bus.rdata            = r_rdata;
  assign bus.load_result      = r_load;
  assign bus.rvalid           = r_rvalid;
  assign bus.misalign_err     = r_err;
  assign bus.stallreq_for_mem = w_stall & ~rst;

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: three instances (0, 3 and 4 wait states) checked
// every cycle against a word-array model with per-access completion times.
module tb_dsram_responder;

  localparam int AW = 5;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_i   [3];
  logic [3:0]  wen_i  [3];
  logic [3:0]  typ_i  [3];
  logic [31:0] addr_i [3];
  logic [31:0] wd_i   [3];
  logic [31:0] rdata_o[3];
  logic [31:0] load_o [3];
  logic        rv_o   [3];
  logic        err_o  [3];
  logic        st_o   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dsram_responder_if bus ();
    assign bus.data_sram_en    = en_i[gi];
    assign bus.data_sram_wen   = wen_i[gi];
    assign bus.data_sram_addr  = addr_i[gi];
    assign bus.data_sram_wdata = wd_i[gi];
    assign bus.data_ram_read   = typ_i[gi];
    assign rdata_o[gi] = bus.rdata;
    assign load_o[gi]  = bus.load_result;
    assign rv_o[gi]    = bus.rvalid;
    assign err_o[gi]   = bus.misalign_err;
    assign st_o[gi]    = bus.stallreq_for_mem;
    dsram_responder #(
      .ADDR_W      (AW),
      .WAIT_CYCLES ((gi == 0) ? 0 : ((gi == 1) ? 3 : 4))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct {
    int          d;
    int          due;
    logic [31:0] rd;
    logic [31:0] ld;
    logic        err;
    logic        kn;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mdl  [3][NW];
  logic        kn_m [3][NW];
  int          st_c [3];
  logic [31:0] out_rd[3];
  logic [31:0] out_ld[3];
  logic        out_kn[3];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // One access: predict the response, drive the request for W+1 cycles, record stall per cycle
  task automatic access(input int d, input logic [3:0] t, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] wd, output logic [15:0] pat);
    int          wt   = wait_of(d);
    int          idx  = int'(a[AW+1:2]);
    logic [1:0]  off  = a[1:0];
    logic [31:0] word = mdl[d][idx];
    bit          is_b = (t == 4'd1) || (t == 4'd2) || (t == 4'd5);
    bit          is_h = (t == 4'd3) || (t == 4'd4) || (t == 4'd7);
    bit          mis  = is_h ? off[0] : (is_b ? 1'b0 : (off != 2'b00));
    logic [31:0] ld   = 32'h0;
    resp_t       r;
    if (!mis && w == 4'b0000) begin
      if (is_b) begin
        ld = (word >> (8 * off)) & 32'hFF;
        if (t == 4'd1 && ld[7]) ld = ld | 32'hFFFF_FF00;
      end else if (is_h) begin
        ld = (word >> (16 * off[1])) & 32'hFFFF;
        if (t == 4'd3 && ld[15]) ld = ld | 32'hFFFF_0000;
      end else begin
        ld = word;
      end
    end
    r.d = d; r.due = cyc + wt + 1; r.err = mis;
    r.rd = mis ? 32'h0 : word; r.ld = ld; r.kn = mis || kn_m[d][idx];
    if (!mis) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
      if (w == 4'hF) kn_m[d][idx] = 1'b1;
    end
    exp_q.push_back(r);
    st_c[d]   = cyc;
    en_i[d]   = 1'b1; wen_i[d] = w; typ_i[d] = t; addr_i[d] = a; wd_i[d] = wd;
    pat = 16'h0;
    for (int k = 0; k <= wt; k++) begin
      #3;
      pat[k] = st_o[d];
      @(posedge clk); #1;
    end
    en_i[d] = 1'b0;
  endtask

  task automatic dchk(input int d, input string nm, input logic [31:0] rd,
                      input logic [31:0] ld, input logic er);
    chk({nm, ".rvalid"}, d, 32'(rv_o[d]), 32'h1);
    chk({nm, ".err"},    d, 32'(err_o[d]), 32'(er));
    chk({nm, ".rdata"},  d, rdata_o[d], rd);
    chk({nm, ".load"},   d, load_o[d], ld);
  endtask

  // Every-cycle comparison of all five outputs against the model
  always @(negedge clk) begin
    logic e_rv, e_err, e_st;
    for (int d = 0; d < 3; d++) begin
      e_rv = 1'b0; e_err = 1'b0; e_st = 1'b0;
      if (rst) begin
        out_rd[d] = 32'h0; out_ld[d] = 32'h0; out_kn[d] = 1'b1;
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].d == d && exp_q[i].due == cyc) begin
            e_rv = 1'b1; e_err = exp_q[i].err;
            out_rd[d] = exp_q[i].rd; out_ld[d] = exp_q[i].ld; out_kn[d] = exp_q[i].kn;
            exp_q.delete(i);
            break;
          end
        end
        e_st = (cyc >= st_c[d]) && ((cyc - st_c[d]) < wait_of(d));
      end
      chk("cmp.rvalid", d, 32'(rv_o[d]), 32'(e_rv));
      chk("cmp.err",    d, 32'(err_o[d]), 32'(e_err));
      chk("cmp.stall",  d, 32'(st_o[d]), 32'(e_st));
      if (out_kn[d]) begin
        chk("cmp.rdata", d, rdata_o[d], out_rd[d]);
        chk("cmp.load",  d, load_o[d], out_ld[d]);
      end
    end
    if (rst) exp_q.delete();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    logic [3:0]  rd_types [8];
    logic [3:0]  wr_types [4];
    rd_types = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd9, 4'd15};
    wr_types = '{4'd0, 4'd5, 4'd7, 4'd12};
    for (int d = 0; d < 3; d++) begin
      en_i[d] = 1'b0; wen_i[d] = 4'h0; typ_i[d] = 4'h0; addr_i[d] = 32'h0; wd_i[d] = 32'h0;
      st_c[d] = -1000; out_rd[d] = 32'h0; out_ld[d] = 32'h0; out_kn[d] = 1'b1;
      for (int i = 0; i < NW; i++) begin
        mdl[d][i] = 32'h0; kn_m[d][i] = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset.rvalid", d, 32'(rv_o[d]), 32'h0);
      chk("reset.stall",  d, 32'(st_o[d]), 32'h0);
      chk("reset.rdata",  d, rdata_o[d], 32'h0);
      chk("reset.load",   d, load_o[d], 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill every word so later reads are fully predictable (upper address bits random)
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NW; i++)
        access(d, 4'd0, 4'hF, {$urandom_range(0, 255), 17'h0, 5'(i), 2'b00}, $urandom, pat);

    // No-wait instance: word, byte and half traffic on word 0x100
    access(0, 4'd0, 4'hF, 32'h100, 32'h1122_3344, pat);
    access(0, 4'd0, 4'h0, 32'h100, 32'h0, pat);
    dchk(0, "lw100", 32'h1122_3344, 32'h1122_3344, 1'b0);
    chk("lw100.stall", 0, 32'(pat[0]), 32'h0);
    access(0, 4'd5, 4'b0010, 32'h101, 32'h0000_AB00, pat);
    dchk(0, "sb101", 32'h1122_3344, 32'h0, 1'b0);
    access(0, 4'd1, 4'h0, 32'h101, 32'h0, pat);
    dchk(0, "lb101", 32'h1122_AB44, 32'hFFFF_FFAB, 1'b0);
    access(0, 4'd2, 4'h0, 32'h101, 32'h0, pat);
    dchk(0, "lbu101", 32'h1122_AB44, 32'h0000_00AB, 1'b0);
    access(0, 4'd7, 4'b1100, 32'h102, 32'h8001_0000, pat);
    access(0, 4'd3, 4'h0, 32'h102, 32'h0, pat);
    dchk(0, "lh102", 32'h8001_AB44, 32'hFFFF_8001, 1'b0);
    access(0, 4'd4, 4'h0, 32'h102, 32'h0, pat);
    dchk(0, "lhu102", 32'h8001_AB44, 32'h0000_8001, 1'b0);
    access(0, 4'd3, 4'h0, 32'h103, 32'h0, pat);
    dchk(0, "lh103mis", 32'h0, 32'h0, 1'b1);
    access(0, 4'd0, 4'hF, 32'h102, 32'hDEAD_BEEF, pat);
    dchk(0, "sw102mis", 32'h0, 32'h0, 1'b1);
    access(0, 4'd0, 4'h0, 32'h100, 32'h0, pat);
    dchk(0, "lw100after", 32'h8001_AB44, 32'h8001_AB44, 1'b0);

    // Three wait states: stall in accept + two BUSY cycles, low in the last one
    access(1, 4'd0, 4'hF, 32'h40, 32'hCAFE_F00D, pat);
    access(1, 4'd0, 4'h0, 32'h40, 32'h0, pat);
    dchk(1, "w3lw40", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    chk("w3lw40.stallpat", 1, 32'(pat[3:0]), 32'h7);

    // Four wait states: reset lands in the second BUSY cycle of a store
    access(2, 4'd0, 4'hF, 32'h20, 32'h55AA_55AA, pat);
    en_i[2] = 1'b1; wen_i[2] = 4'hF; typ_i[2] = 4'd0; addr_i[2] = 32'h20; wd_i[2] = 32'h1234_5678;
    st_c[2] = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    st_c[2] = -1000;
    @(negedge clk); #1;
    chk("rstbusy.rvalid", 2, 32'(rv_o[2]), 32'h0);
    chk("rstbusy.stall",  2, 32'(st_o[2]), 32'h0);
    chk("rstbusy.rdata",  2, rdata_o[2], 32'h0);
    chk("rstbusy.load",   2, load_o[2], 32'h0);
    @(posedge clk); #1;
    en_i[2] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    access(2, 4'd0, 4'h0, 32'h20, 32'h0, pat);
    dchk(2, "w4lw20", 32'h55AA_55AA, 32'h55AA_55AA, 1'b0);
    chk("w4lw20.stallpat", 2, 32'(pat[4:0]), 32'hF);

    // Randomised mix of loads/stores of every width, aligned and not, with idle gaps
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 120; n++) begin
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        if ($urandom_range(0, 1) == 1)
          access(d, rd_types[$urandom_range(0, 7)], 4'h0, a, 32'h0, pat);
        else
          access(d, wr_types[$urandom_range(0, 3)], 4'($urandom_range(1, 15)), a, $urandom, pat);
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain", 0, 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Responder end of the EX-stage data-memory interface. Accepts the en/wen/addr/wdata request that EX drives and holds the backing word-organised data SRAM.
- Performs byte-lane writes and registered reads with a configurable number of wait states.
- Returns the raw read word and the sign/zero-extended load result to MEM.
- Raises stallreq_for_mem into the stall controller while an access is pending.

Parameters:
- ADDR_W, 12, word-address bits; depth is 2^ADDR_W words; byte address bits [ADDR_W+1:2] index the array, higher bits ignored (aliasing).
- WAIT_CYCLES, 0, extra cycles before an access completes (0..15); 0 means single-cycle completion.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_sram_en  in  1  request valid
- data_sram_wen  in  4  byte write enables; 4'b0000 means read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  lane-aligned write data
- data_ram_read  in  4  access type code (see package)
- rdata  out  32  raw word read
- load_result  out  32  extended load value
- rvalid  out  1  one-cycle pulse, read/write completion response
- misalign_err  out  1  one-cycle pulse with rvalid, access suppressed
- stallreq_for_mem  out  1  hold upstream pipeline

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, state goes to IDLE, counter goes to 0, latched request is cleared. SRAM contents are not reset.
- Type codes: 0000 lw/sw, 0001 lb, 0010 lbu, 0011 lh, 0100 lhu, 0101 sb, 0111 sh. Other codes behave as 0000.
- Misalignment:
  - lh/lhu/sh: addr[0]=1.
  - lw/sw: addr[1:0]!=0.
  - Byte accesses are never misaligned.
  - A misaligned access writes nothing. rdata and load_result are 0. misalign_err pulses together with rvalid.
- Completion edge: the write is committed and the read word is captured.
  - Write: only lanes with wen=1 are updated, using wdata bits from the same lanes.
  - Read: the whole word is captured.
  - rdata, load_result and rvalid update on the edge after completion and stay valid exactly one cycle; rvalid then returns to 0. rdata/load_result hold their last value while rvalid=0.
- Load extraction uses the latched addr[1:0] and type:
  - lb/lbu: selected byte, sign- or zero-extended.
  - lh/lhu: half selected by addr[1], extended.
  - lw: full word.
  - Writes return rdata = pre-write word; load_result = 0.
- FSM states: IDLE, BUSY.
  - IDLE, en=0: stay.
  - IDLE, en=1, WAIT_CYCLES=0: complete on this edge, stay IDLE, stallreq=0.
  - IDLE, en=1, WAIT_CYCLES>0: latch addr/wen/wdata/type, set counter=WAIT_CYCLES, go BUSY. stallreq=1 combinationally in this accept cycle.
  - BUSY: counter decrements each edge. stallreq=1 while counter!=1; stallreq=0 in the counter==1 cycle. At the end of that cycle the access completes and the FSM goes to IDLE.
- Inputs in BUSY are ignored; EX re-presents the held request and this must not start a second access.
- Back-to-back requests:
  - WAIT_CYCLES=0: sustained one access per cycle.
  - Otherwise: a new request is accepted in the first IDLE cycle.
- Read after write to the same word in consecutive accesses returns the written data; no bypass is needed because the write is committed before the next read.
- Reset mid-BUSY: the access is abandoned with no write, no rvalid, and the FSM returns to IDLE.

Decomposition:
- Shared package/defines file (dsram_defs) holds:
  - type codes LD_W, LD_B, LD_BU, LD_H, LD_HU, ST_B, ST_H;
  - state encodings S_IDLE, S_BUSY;
  - DSRAM_WAIT_MAX = 15.
- One combinational sub-module, load_ext, maps (word, addr[1:0], type) to load_result. MEM reuses it.
- FSM, counter and array remain in dsram_responder.

Test Plan:
- WAIT=0: sw 0x11223344 to 0x100, then lw 0x100 -> rvalid on the next cycle, rdata=0x11223344; stallreq never asserted.
- WAIT=0: sb wen=0010 wdata=0x0000AB00 to 0x101 over word 0x11223344, then lb 0x101 -> rdata=0x1122AB44, load_result=0xFFFFFFAB; lbu -> 0x000000AB.
- WAIT=0: sh wen=1100 wdata=0x80010000 to 0x102, then lh 0x102 -> load_result=0xFFFF8001; lhu -> 0x00008001.
- WAIT=3: lw with en held -> stallreq=1 for 3 cycles (accept cycle plus BUSY while counter=3,2), 0 in counter=1 cycle, rvalid one cycle later; exactly one access occurs.
- lh at 0x103 and sw at 0x102 -> misalign_err=1 with rvalid, load_result=0, memory unchanged on readback.
- WAIT=4: assert rst during the second BUSY cycle of an sw -> all outputs 0, FSM IDLE, no rvalid, target word unchanged.
